// File: rtl/mctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM driving every datapath control input.
// Define MCTRL_OVF_TRAP_EN to enable the sticky overflow trap (suppresses write-back on overflow).
module mctrl_fsm #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned STATE_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [2:0]         ALU_operation,
  output logic               unsign,
  output logic               ovf_flag,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    StIf = 4'd0, StId = 4'd1, StMemAddr = 4'd2, StMemRd = 4'd3, StLwWb = 4'd4,
    StMemWr = 4'd5, StRExe = 4'd6, StRWb = 4'd7, StBr = 4'd8, StJmp = 4'd9,
    StIExe = 4'd10, StIWb = 4'd11, StLuiWb = 4'd12, StJr = 4'd13, StJal = 4'd14
  } state_e;

  localparam logic [2:0] AluAnd = 3'b000, AluOr  = 3'b001, AluAdd = 3'b010, AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100, AluSrl = 3'b101, AluSub = 3'b110, AluSlt = 3'b111;

  state_e state_q, state_d, dec_st;
  logic [5:0] opcode, funct;
  logic ready, r_known, i_unsign, ovf_block;
  logic [2:0] r_alu_op, i_alu_op;
  logic mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw, pc_write_raw, pc_cond_raw;
  logic unused_bits;

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];
  assign ready  = MIO_ready | ~MEM_WAIT_EN;

  always_comb begin
    r_known  = 1'b1;
    r_alu_op = AluAdd;
    case (funct)
      6'b100000: r_alu_op = AluAdd;
      6'b100010: r_alu_op = AluSub;
      6'b100100: r_alu_op = AluAnd;
      6'b100101: r_alu_op = AluOr;
      6'b100110: r_alu_op = AluXor;
      6'b100111: r_alu_op = AluNor;
      6'b101010: r_alu_op = AluSlt;
      6'b000010: r_alu_op = AluSrl;
      default:   r_known  = 1'b0;
    endcase
  end

  always_comb begin
    i_unsign = 1'b0;
    i_alu_op = AluAdd;
    case (opcode)
      6'b001100: begin i_alu_op = AluAnd; i_unsign = 1'b1; end
      6'b001101: begin i_alu_op = AluOr;  i_unsign = 1'b1; end
      6'b001110: begin i_alu_op = AluXor; i_unsign = 1'b1; end
      6'b001010: i_alu_op = AluSlt;
      default:   i_alu_op = AluAdd;
    endcase
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = ready ? StId : StIf;
      StId: begin
        case (opcode)
          6'b100011, 6'b101011: state_d = StMemAddr;
          6'b000000:            state_d = (funct == 6'b001000) ? StJr : StRExe;
          6'b000100, 6'b000101: state_d = StBr;
          6'b000010:            state_d = StJmp;
          6'b000011:            state_d = StJal;
          6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: state_d = StIExe;
          6'b001111:            state_d = StLuiWb;
          default:              state_d = StIf;
        endcase
      end
      StMemAddr: state_d = (opcode == 6'b101011) ? StMemWr : StMemRd;
      StMemRd:   state_d = ready ? StLwWb : StMemRd;
      StMemWr:   state_d = ready ? StIf : StMemWr;
      StRExe:    state_d = StRWb;
      StIExe:    state_d = StIWb;
      default:   state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIf;
    else       state_q <= state_d;
  end

  // During reset the outputs show the IF decode, with all enables masked below.
  assign dec_st = reset ? StIf : state_q;

  always_comb begin
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_write_raw  = 1'b0;
    pc_cond_raw   = 1'b0;
    IorD          = 1'b0;
    RegDst        = 2'd0;
    MemtoReg      = 2'd0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'd0;
    PCSource      = 2'd0;
    Branch        = 1'b0;
    ALU_operation = AluAnd;
    unsign        = 1'b0;
    case (dec_st)
      StIf: begin
        mem_read_raw = 1'b1; ALUSrcB = 2'd1; ALU_operation = AluAdd;
        pc_write_raw = 1'b1; ir_write_raw = ready;
      end
      StId:      begin ALUSrcB = 2'd3; ALU_operation = AluAdd; end
      StMemAddr: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALU_operation = AluAdd; end
      StMemRd:   begin mem_read_raw = 1'b1; IorD = 1'b1; end
      StLwWb:    begin MemtoReg = 2'd1; reg_write_raw = 1'b1; end
      StMemWr:   begin mem_write_raw = 1'b1; IorD = 1'b1; end
      StRExe:    begin ALUSrcA = 1'b1; ALU_operation = r_alu_op; end
      StRWb:     begin RegDst = 2'd1; reg_write_raw = r_known & ~ovf_block; end
      StBr: begin
        ALUSrcA = 1'b1; ALU_operation = AluSub; pc_cond_raw = 1'b1;
        PCSource = 2'd1; Branch = ~Inst[26];
      end
      StJmp:     begin PCSource = 2'd2; pc_write_raw = 1'b1; end
      StIExe: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALU_operation = i_alu_op; unsign = i_unsign;
      end
      StIWb:     reg_write_raw = ~ovf_block;
      StLuiWb:   begin MemtoReg = 2'd2; reg_write_raw = 1'b1; end
      StJr:      begin ALUSrcA = 1'b1; ALU_operation = AluAdd; pc_write_raw = 1'b1; end
      StJal: begin
        RegDst = 2'd2; MemtoReg = 2'd3; reg_write_raw = 1'b1;
        PCSource = 2'd2; pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign MemRead     = mem_read_raw & ~reset;
  assign MemWrite    = mem_write_raw & ~reset;
  assign IRWrite     = ir_write_raw & ~reset;
  assign RegWrite    = reg_write_raw & ~reset;
  assign PCWrite     = pc_write_raw & ~reset;
  assign PCWriteCond = pc_cond_raw & ~reset;
  assign CPU_MIO     = MemRead | MemWrite;
  assign state       = STATE_W'(state_q);

`ifdef MCTRL_OVF_TRAP_EN
  logic ovf_pend_q, ovf_flag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_pend_q <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      if (state_d == StIf) begin
        ovf_pend_q <= 1'b0;
      end else if ((state_q == StRExe && (funct == 6'b100000 || funct == 6'b100010)) ||
                   (state_q == StIExe && opcode == 6'b001000)) begin
        ovf_pend_q <= overflow;
      end
      if ((state_q == StRWb || state_q == StIWb) && ovf_pend_q) ovf_flag_q <= 1'b1;
    end
  end

  assign ovf_block   = ovf_pend_q;
  assign ovf_flag    = ovf_flag_q;
  assign unused_bits = ^{Inst[25:6], zero};
`else
  assign ovf_block   = 1'b0;
  assign ovf_flag    = 1'b0;
  assign unused_bits = ^{Inst[25:6], zero, overflow};
`endif

endmodule

// File: tb/tb_mctrl_fsm.sv
// Directed bench for mctrl_fsm: walks each instruction class and checks per-state decode.
module tb_mctrl_fsm;

`ifdef MCTRL_OVF_TRAP_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk, reset, zero, overflow, MIO_ready;
  logic [31:0] Inst;
  logic MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch, unsign, ovf_flag;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0] ALU_operation;
  logic [4:0] state;
  int n_pass, n_total;

  mctrl_fsm #(.MEM_WAIT_EN(1'b1), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation), .unsign(unsign), .ovf_flag(ovf_flag), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Enable bundle: {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite}
  task automatic test_reset();
    reset = 1'b1; MIO_ready = 1'b1; Inst = 32'h0; zero = 1'b0; overflow = 1'b0;
    tick(); tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_total++;
    if ({PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, CPU_MIO} !== 7'b0)
      $display("FAIL reset_enables got %b want 0", {PCWrite, PCWriteCond, IRWrite, RegWrite,
                MemRead, MemWrite, CPU_MIO});
    else n_pass++;
    n_total++;
    if ({ALUSrcB, ALU_operation} !== {2'd1, 3'b010})
      $display("FAIL reset_if_decode got %b want %b", {ALUSrcB, ALU_operation}, 5'b01010);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({IRWrite, MemRead, PCWrite, CPU_MIO, IorD} !== 5'b11110)
      $display("FAIL post_reset_if got %b want 11110", {IRWrite, MemRead, PCWrite, CPU_MIO, IorD});
    else n_pass++;
  endtask

  task automatic test_if_stall();
    MIO_ready = 1'b0;
    #1;
    n_total++;
    if (IRWrite !== 1'b0) $display("FAIL if_stall_irwrite got %b want 0", IRWrite); else n_pass++;
    tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL if_stall_state got %0d want 0", state); else n_pass++;
    MIO_ready = 1'b1;
  endtask

  task automatic test_itype(input logic [31:0] inst, input logic [2:0] op, input logic uns);
    Inst = inst;
    tick();
    n_total++;
    if ({state, ALUSrcB, ALUSrcA} !== {5'd1, 2'd3, 1'b0})
      $display("FAIL id_decode got %b want %b", {state, ALUSrcB, ALUSrcA}, {5'd1, 2'd3, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if ({state, ALUSrcA, ALUSrcB, ALU_operation, unsign} !== {5'd10, 1'b1, 2'd2, op, uns})
      $display("FAIL iexe got %b want %b", {state, ALUSrcA, ALUSrcB, ALU_operation, unsign},
               {5'd10, 1'b1, 2'd2, op, uns});
    else n_pass++;
    tick();
    n_total++;
    if ({state, RegWrite, RegDst, MemtoReg} !== {5'd11, 1'b1, 2'd0, 2'd0})
      $display("FAIL iwb got %b want %b", {state, RegWrite, RegDst, MemtoReg},
               {5'd11, 1'b1, 2'd0, 2'd0});
    else n_pass++;
    tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL iwb_return got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_lw();
    Inst = 32'h8C220004;
    tick(); tick();
    n_total++;
    if ({state, ALUSrcA, ALUSrcB, ALU_operation} !== {5'd2, 1'b1, 2'd2, 3'b010})
      $display("FAIL memaddr got %b want %b", {state, ALUSrcA, ALUSrcB, ALU_operation},
               {5'd2, 1'b1, 2'd2, 3'b010});
    else n_pass++;
    MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({state, MemRead, IorD, CPU_MIO, MemWrite} !== {5'd3, 1'b1, 1'b1, 1'b1, 1'b0})
        $display("FAIL lw_stall_%0d got %b want %b", i, {state, MemRead, IorD, CPU_MIO, MemWrite},
                 {5'd3, 1'b1, 1'b1, 1'b1, 1'b0});
      else n_pass++;
    end
    MIO_ready = 1'b1;
    tick();
    n_total++;
    if ({state, MemtoReg, RegWrite, RegDst, MemRead} !== {5'd4, 2'd1, 1'b1, 2'd0, 1'b0})
      $display("FAIL lw_wb got %b want %b", {state, MemtoReg, RegWrite, RegDst, MemRead},
               {5'd4, 2'd1, 1'b1, 2'd0, 1'b0});
    else n_pass++;
    tick();
  endtask

  task automatic test_sw();
    Inst = 32'hAC220004;
    tick(); tick(); tick();
    n_total++;
    if ({state, MemWrite, IorD, CPU_MIO, MemRead} !== {5'd5, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL sw_memwr got %b want %b", {state, MemWrite, IorD, CPU_MIO, MemRead},
               {5'd5, 1'b1, 1'b1, 1'b1, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL sw_return got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_branch(input logic [31:0] inst, input logic br);
    Inst = inst;
    tick(); tick();
    n_total++;
    if ({state, PCWriteCond, Branch, ALU_operation, PCSource, PCWrite, ALUSrcA} !==
        {5'd8, 1'b1, br, 3'b110, 2'd1, 1'b0, 1'b1})
      $display("FAIL branch got %b want %b", {state, PCWriteCond, Branch, ALU_operation,
               PCSource, PCWrite, ALUSrcA}, {5'd8, 1'b1, br, 3'b110, 2'd1, 1'b0, 1'b1});
    else n_pass++;
    tick();
  endtask

  task automatic test_jumps();
    Inst = 32'h0C000010;
    tick(); tick();
    n_total++;
    if ({state, RegDst, MemtoReg, RegWrite, PCWrite, PCSource} !==
        {5'd14, 2'd2, 2'd3, 1'b1, 1'b1, 2'd2})
      $display("FAIL jal got %b want %b", {state, RegDst, MemtoReg, RegWrite, PCWrite, PCSource},
               {5'd14, 2'd2, 2'd3, 1'b1, 1'b1, 2'd2});
    else n_pass++;
    tick();
    Inst = 32'h03E00008;
    tick(); tick();
    n_total++;
    if ({state, PCSource, PCWrite, ALUSrcA, RegWrite} !== {5'd13, 2'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL jr got %b want %b", {state, PCSource, PCWrite, ALUSrcA, RegWrite},
               {5'd13, 2'd0, 1'b1, 1'b1, 1'b0});
    else n_pass++;
    tick();
    Inst = 32'h08000010;
    tick(); tick();
    n_total++;
    if ({state, PCSource, PCWrite} !== {5'd9, 2'd2, 1'b1})
      $display("FAIL j got %b want %b", {state, PCSource, PCWrite}, {5'd9, 2'd2, 1'b1});
    else n_pass++;
    tick();
  endtask

  task automatic test_rtype(input logic [31:0] inst, input logic [2:0] op, input logic ovf,
                            input logic exp_wr, input logic exp_flag);
    Inst = inst;
    tick(); tick();
    overflow = ovf;
    n_total++;
    if ({state, ALUSrcA, ALUSrcB, ALU_operation} !== {5'd6, 1'b1, 2'd0, op})
      $display("FAIL rexe got %b want %b", {state, ALUSrcA, ALUSrcB, ALU_operation},
               {5'd6, 1'b1, 2'd0, op});
    else n_pass++;
    tick();
    overflow = 1'b0;
    n_total++;
    if ({state, RegDst, MemtoReg, RegWrite} !== {5'd7, 2'd1, 2'd0, exp_wr})
      $display("FAIL rwb got %b want %b", {state, RegDst, MemtoReg, RegWrite},
               {5'd7, 2'd1, 2'd0, exp_wr});
    else n_pass++;
    tick();
    n_total++;
    if ({state, ovf_flag} !== {5'd0, exp_flag})
      $display("FAIL ovf_flag got %b want %b", {state, ovf_flag}, {5'd0, exp_flag});
    else n_pass++;
  endtask

  task automatic test_nop_and_lui();
    Inst = 32'hFC000000;
    tick(); tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL nop_return got %0d want 0", state); else n_pass++;
    Inst = 32'h3C011234;
    tick(); tick();
    n_total++;
    if ({state, MemtoReg, RegWrite, RegDst} !== {5'd12, 2'd2, 1'b1, 2'd0})
      $display("FAIL lui got %b want %b", {state, MemtoReg, RegWrite, RegDst},
               {5'd12, 2'd2, 1'b1, 2'd0});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_abort();
    Inst = 32'h8C220004;
    tick(); tick();
    MIO_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if ({MemRead, CPU_MIO, IorD} !== 3'b000)
      $display("FAIL abort_comb got %b want 000", {MemRead, CPU_MIO, IorD});
    else n_pass++;
    tick();
    n_total++;
    if (state !== 5'd0) $display("FAIL abort_state got %0d want 0", state); else n_pass++;
    MIO_ready = 1'b1;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_if_stall();
    test_itype(32'h20010005, 3'b010, 1'b0);
    test_itype(32'h3021000F, 3'b000, 1'b1);
    test_lw();
    test_sw();
    test_branch(32'h14220003, 1'b0);
    test_branch(32'h10220003, 1'b1);
    test_jumps();
    test_rtype(32'h00221820, 3'b010, 1'b1, !OvfEn, OvfEn);
    test_rtype(32'h00221822, 3'b110, 1'b0, 1'b1, OvfEn);
    test_rtype(32'h0022183F, 3'b010, 1'b0, 1'b0, OvfEn);
    test_nop_and_lui();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mctrl_fsm.md
Name: mctrl_fsm

Overview:
- Multicycle MIPS control unit; sits directly upstream of the multicycle datapath and drives every datapath control input.
- Consumes the datapath's `Inst`, `zero`, `overflow` and the memory-ready handshake `MIO_ready`.
- Moore FSM: one instruction takes 3–5 states. Memory access states stall until `MIO_ready`.

Parameters:
- MEM_WAIT_EN, 1: 1 = IF/MEM_RD/MEM_WR hold until MIO_ready=1; 0 = MIO_ready ignored (single-cycle memory).
- STATE_W, 5: width of the `state` debug output.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Inst  in  32  IR contents from datapath
- zero  in  1  ALU zero flag (combinational)
- overflow  in  1  ALU overflow flag (combinational)
- MIO_ready  in  1  memory access complete
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- CPU_MIO  out  1  memory/IO access in progress (MemRead|MemWrite)
- IorD  out  1  0 = PC addresses memory, 1 = ALU_Out addresses memory
- IRWrite  out  1  IR load
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31
- RegWrite  out  1  register file write
- MemtoReg  out  2  0 = ALU_Out, 1 = MDR, 2 = lui, 3 = PC
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  0 = rt, 1 = 4, 2 = imm, 3 = imm<<2
- PCSource  out  2  0 = ALU result, 1 = ALU_Out, 2 = jump address
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load
- Branch  out  1  1 = beq (load on zero), 0 = bne
- ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT
- unsign  out  1  1 = zero-extend imm (andi/ori/xori)
- ovf_flag  out  1  sticky overflow indicator (feature only; else tied 0)
- state  out  STATE_W  current state code

Behaviour:
- Reset: reset=1 at a clock edge → state=IF.
- While reset=1, PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite are forced 0. All other outputs take the IF decode.
- Outputs decode from the state register. The one exception is IRWrite = (state==IF) & ready, where ready = MIO_ready | ~MEM_WAIT_EN.
- Any output not listed for a state is 0.
- States and codes:
  - IF(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1.
    - PC updates only when ready; the datapath gates this.
    - ready → ID; else hold.
  - ID(1): ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALU_Out). Dispatch on opcode Inst[31:26]:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 → R_EXE; if funct=001000 → JR
    - 000100 (beq) or 000101 (bne) → BR
    - 000010 (j) → JMP
    - 000011 (jal) → JAL
    - 001000 / 001100 / 001101 / 001110 / 001010 (addi / andi / ori / xori / slti) → I_EXE
    - 001111 (lui) → LUI_WB
    - anything else → IF (executes as NOP)
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=2, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(3): MemRead, IorD=1. ready → LW_WB; else hold.
  - LW_WB(4): RegDst=0, MemtoReg=1, RegWrite → IF.
  - MEM_WR(5): MemWrite, IorD=1. ready → IF; else hold.
  - R_EXE(6): ALUSrcA=1, ALUSrcB=0, ALU_operation from funct → R_WB.
    - funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL.
    - Unknown funct → ADD with RegWrite suppressed in R_WB.
  - R_WB(7): RegDst=1, MemtoReg=0, RegWrite → IF.
  - BR(8): ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond, PCSource=1, Branch=~Inst[26] → IF.
  - JMP(9): PCSource=2, PCWrite → IF.
  - I_EXE(10): ALUSrcA=1, ALUSrcB=2, unsign per opcode.
    - ALU op: ADD for addi, AND for andi, OR for ori, XOR for xori, SLT for slti.
    - → I_WB.
  - I_WB(11): RegDst=0, MemtoReg=0, RegWrite → IF.
  - LUI_WB(12): RegDst=0, MemtoReg=2, RegWrite → IF.
  - JR(13): ALUSrcA=1, ALUSrcB=0, ADD (rs+$0), PCSource=0, PCWrite → IF.
  - JAL(14): RegDst=2, MemtoReg=3 (PC already = PC+4), RegWrite, PCSource=2, PCWrite → IF.
- Unused state codes → IF on next edge; all enables 0 while in them.
- CPI: lw 5; sw, R-type, I-type 4; lui, branch, j, jal, jr 3 (excluding wait states).
- `unsign` and ALU controls are held for the full duration of MEM_RD/MEM_WR stalls. A reset during a stall aborts the access.

Optional Feature:
- MCTRL_OVF_TRAP_EN defined:
  - In R_EXE (funct ADD/SUB) and I_EXE (addi), `overflow` is registered into ovf_pend.
  - If ovf_pend=1 in R_WB or I_WB, RegWrite is forced 0 and ovf_flag is set.
  - ovf_flag is sticky; it clears only on reset. ovf_pend clears on entering IF.
- Undefined: no overflow register; ovf_flag tied 0; overflow ignored.

Test Plan:
- Reset held for 2 cycles, then released with MIO_ready=1 → state=0, no write enables during reset; IRWrite=1 in the first post-reset cycle.
- Inst=0x20010005 (addi $1,$0,5), MIO_ready=1 → states 0,1,10,11,0.
  - I_EXE: ALUSrcB=2, ALU_operation=010, unsign=0.
  - I_WB: RegWrite=1, RegDst=0.
- Inst=0x8C220004 (lw) with MIO_ready low for 3 cycles in MEM_RD → state holds at 3 for 3 cycles, MemRead=1, IorD=1; then LW_WB with MemtoReg=1.
- Inst=0x14220003 (bne) → BR state with PCWriteCond=1, Branch=0, ALU_operation=110, PCSource=1. Inst=0x10220003 → Branch=1.
- Inst=0x0C000010 (jal) → states 0,1,14 with RegDst=2, MemtoReg=3, RegWrite=1, PCWrite=1, PCSource=2. Inst=0x03E00008 (jr $31) → state 13, PCSource=0.
- MCTRL_OVF_TRAP_EN, Inst=0x00221820 (add) with overflow=1 in R_EXE → R_WB RegWrite=0, ovf_flag=1, stays 1 after the next instruction.
